rr_arb4: RTL and testbench
==========================

RR_ARB4 -- requirements
Module: rr_arb4

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive BUSY cycles per grant (legal range 2..15); it is used only when HOLD_TIMEOUT_EN is defined.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: per-requester request, level; bit i is held by requester i until it is done with the resource.
REQ-005 The block SHALL have port en, input, 1 bit: arbitration enable.
REQ-006 The block SHALL have port gnt, output, 4 bits: registered grant, one-hot or all-zero.
REQ-007 The block SHALL have port owner, output, 2 bits: registered index of the current or most recent grantee.
REQ-008 The block SHALL have port busy, output, 1 bit: registered, high while in state BUSY.
REQ-009 The block SHALL have port req_up, output, 1 bit: combinational, en & (|req).

Function
REQ-010 The block SHALL implement two states: IDLE, where gnt = 0, and BUSY, where gnt = one-hot(owner).
REQ-011 In IDLE with en=1 and req!=0, the block SHALL select the winner by rotating priority, searching downward from index (last-1) mod 4 and wrapping 0->3, where last = owner register.
REQ-012 On selection, the block SHALL set gnt <= one-hot(winner), owner <= winner and state <= BUSY at the next edge (1-cycle request-to-grant latency).
REQ-013 In IDLE with en=0 or req=0, the block SHALL hold state and keep gnt=0 and owner unchanged.
REQ-014 In BUSY, the block SHALL hold gnt and owner unchanged while req[owner]=1 and en=1; changes on other req bits are ignored.
REQ-015 In BUSY, if req[owner]=0 or en=0, the block SHALL set gnt <= 0 and state <= IDLE at the next edge, which gives one mandatory dead cycle between consecutive grants.
REQ-016 The just-released owner SHALL have lowest priority in the next arbitration; if it is the only requester, it SHALL be regranted after the dead cycle.
REQ-017 When several requests rise in the same cycle, the block SHALL grant exactly one requester, chosen per REQ-011.
REQ-018 The block SHALL never drive more than one gnt bit high.
REQ-019 If req and en drop in the same cycle as a BUSY hold, release per REQ-015 SHALL take precedence (a single release, no double action).

Reset
REQ-020 On a reset edge, the block SHALL set state=IDLE, gnt=4'b0000, owner=2'b00, busy=0 and hold counter=0, giving search order 3,2,1,0 first.
REQ-021 Reset asserted mid-BUSY SHALL drop gnt at the next edge regardless of req and en.
REQ-022 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-023 With macro HOLD_TIMEOUT_EN defined, a 4-bit hold counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-024 With HOLD_TIMEOUT_EN defined, when the counter equals MAX_HOLD-1 and the block is still BUSY, the block SHALL force gnt <= 0 and state <= IDLE even if req[owner]=1.
REQ-025 Without HOLD_TIMEOUT_EN, the block SHALL contain no counter logic, and a grant SHALL persist indefinitely while req[owner]=1 and en=1.

Verification
REQ-026 Scenario: reset, en=1, req=4'b1111 held -> gnt sequence 1000, 0000, 0100, 0000, 0010, 0000, 0001, 0000, 1000 (with timeout, MAX_HOLD=2).
REQ-027 Scenario: en=1, req=4'b0010 for 3 cycles then 0 -> gnt=0010 one cycle after req rises, gnt=0 one cycle after req falls, busy mirrors gnt.
REQ-028 Scenario: BUSY with owner=2, drop en for 1 cycle while req=0100 -> gnt=0 next cycle, no grant while en=0, then regrant 0100 after en returns.
REQ-029 Scenario: reset asserted while gnt=1000 -> gnt=0000, owner=0 next cycle; next grant on req=1001 is 1000.
REQ-030 Scenario: HOLD_TIMEOUT_EN, MAX_HOLD=4, req=0001 held -> gnt=0001 for exactly 4 cycles, 1 cycle 0000, then 0001 again.
REQ-031 Scenario: without HOLD_TIMEOUT_EN, req=0101 held for 50 cycles -> gnt=0100 all 50 cycles; on req[2] drop, dead cycle then gnt=0001.

Source files
------------

// File: rtl/rr_arb4.sv
// rtl/rr_arb4.sv - 4-way round-robin arbiter with registered one-hot grant (optional hold timeout: HOLD_TIMEOUT_EN)
module rr_arb4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       en,
    output logic [3:0] gnt,
    output logic [1:0] owner,
    output logic       busy,
    output logic       req_up
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_gnt;
    logic [1:0]  r_owner;
    logic        r_busy;

    state_t      w_next_state;
    logic [3:0]  w_next_gnt;
    logic [1:0]  w_next_owner;
    logic        w_release;
    logic [1:0]  w_winner;

    // The hold limit has to fit the 4-bit counter and leave room for at least two BUSY cycles.
    if (MAX_HOLD < 2 || MAX_HOLD > 15) begin : g_bad_max_hold
        $error("rr_arb4: MAX_HOLD must be in 2..15");
    end

    // Search downward starting just below the last owner, so the previous owner is tried last.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        logic       found;
        pick_winner = last;
        found       = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last - 2'(k);
            if (!found && r[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    assign w_winner = pick_winner(req, r_owner);

`ifdef HOLD_TIMEOUT_EN
    logic [3:0] r_hold_cnt;
    logic       w_timeout;

    assign w_timeout = (r_state == S_BUSY) && (r_hold_cnt == 4'(MAX_HOLD - 1));

    // Hold counter: zero on entry to BUSY, counts every BUSY cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_cnt <= 4'd0;
        end else if (r_state == S_BUSY) begin
            r_hold_cnt <= r_hold_cnt + 4'd1;
        end else begin
            r_hold_cnt <= 4'd0;
        end
    end

    assign w_release = !en || !req[r_owner] || w_timeout;
`else
    assign w_release = !en || !req[r_owner];
`endif

    // Next-state logic: grant from IDLE on any enabled request, release from BUSY on drop/disable.
    always_comb begin
        w_next_state = r_state;
        w_next_gnt   = r_gnt;
        w_next_owner = r_owner;
        case (r_state)
            S_IDLE: begin
                w_next_gnt = 4'b0000;
                if (en && (req != 4'b0000)) begin
                    w_next_state = S_BUSY;
                    w_next_owner = w_winner;
                    w_next_gnt   = 4'b0001 << w_winner;
                end
            end
            S_BUSY: begin
                if (w_release) begin
                    w_next_state = S_IDLE;
                    w_next_gnt   = 4'b0000;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_gnt   = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset overrides everything else.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_gnt   <= 4'b0000;
            r_owner <= 2'b00;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_gnt   <= w_next_gnt;
            r_owner <= w_next_owner;
            r_busy  <= (w_next_state == S_BUSY);
        end
    end

    assign gnt    = r_gnt;
    assign owner  = r_owner;
    assign busy   = r_busy;
    assign req_up = en & (|req);

endmodule

// File: tb/tb_rr_arb4.sv
// tb/tb_rr_arb4.sv - scoreboard bench for rr_arb4 (default build, no hold timeout)
module tb_rr_arb4;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       req_up;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         id;
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   step_id = 0;

    rr_arb4 #(.MAX_HOLD(8)) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .en    (en),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .req_up(req_up)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of inputs, queue what the registers must hold after the coming edge.
    task automatic step(input logic r, input logic e, input logic [3:0] q,
                        input logic [3:0] egnt, input logic [1:0] eown, input logic ebusy);
        exp_t x;
        logic exp_up;
        reset = r;
        en    = e;
        req   = q;
        x.id    = step_id;
        x.gnt   = egnt;
        x.owner = eown;
        x.busy  = ebusy;
        exp_q.push_back(x);
        exp_up = e && (q != 4'b0000);
        #1;
        total++;
        if (req_up !== exp_up) begin
            bad++;
            $display("FAIL req_up step=%0d got=%b want=%b", step_id, req_up, exp_up);
        end
        step_id++;
        @(posedge clock);
        #2;
    endtask

    // Monitor: registered outputs are valid every cycle; compare against the queue head.
    always @(negedge clock) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            total++;
            if (gnt !== x.gnt) begin
                bad++;
                $display("FAIL gnt step=%0d got=%b want=%b", x.id, gnt, x.gnt);
            end
            total++;
            if (owner !== x.owner) begin
                bad++;
                $display("FAIL owner step=%0d got=%0d want=%0d", x.id, owner, x.owner);
            end
            total++;
            if (busy !== x.busy) begin
                bad++;
                $display("FAIL busy step=%0d got=%b want=%b", x.id, busy, x.busy);
            end
            total++;
            if (!$onehot0(gnt)) begin
                bad++;
                $display("FAIL onehot step=%0d got=%b want=onehot0", x.id, gnt);
            end
        end
    end

    initial begin
        int waited;
        reset = 1'b1;
        en    = 1'b0;
        req   = 4'b0000;
        #2;
        // reset state
        step(1, 0, 4'b0000, 4'b0000, 2'd0, 0);
        step(1, 1, 4'b1111, 4'b0000, 2'd0, 0);
        // all requesting: order 3,2,1,0, dead cycle between grants, others ignored while BUSY
        step(0, 1, 4'b1111, 4'b1000, 2'd3, 1);
        step(0, 1, 4'b1111, 4'b1000, 2'd3, 1);
        step(0, 1, 4'b0111, 4'b0000, 2'd3, 0);
        step(0, 1, 4'b0111, 4'b0100, 2'd2, 1);
        step(0, 1, 4'b1011, 4'b0000, 2'd2, 0);
        step(0, 1, 4'b1011, 4'b0010, 2'd1, 1);
        step(0, 1, 4'b1001, 4'b0000, 2'd1, 0);
        step(0, 1, 4'b1001, 4'b0001, 2'd0, 1);
        step(0, 1, 4'b1000, 4'b0000, 2'd0, 0);
        step(0, 1, 4'b1000, 4'b1000, 2'd3, 1);
        // single pulse on req[1] for three cycles
        step(0, 1, 4'b0000, 4'b0000, 2'd3, 0);
        step(0, 1, 4'b0010, 4'b0010, 2'd1, 1);
        step(0, 1, 4'b0010, 4'b0010, 2'd1, 1);
        step(0, 1, 4'b0010, 4'b0010, 2'd1, 1);
        step(0, 1, 4'b0000, 4'b0000, 2'd1, 0);
        step(0, 1, 4'b0000, 4'b0000, 2'd1, 0);
        // enable drop while owner 2 holds
        step(0, 1, 4'b0100, 4'b0100, 2'd2, 1);
        step(0, 0, 4'b0100, 4'b0000, 2'd2, 0);
        step(0, 0, 4'b0100, 4'b0000, 2'd2, 0);
        step(0, 1, 4'b0100, 4'b0100, 2'd2, 1);
        // sole requester regranted after dead cycle
        step(0, 1, 4'b0000, 4'b0000, 2'd2, 0);
        step(0, 1, 4'b0100, 4'b0100, 2'd2, 1);
        // req and en drop together: single release
        step(0, 0, 4'b0000, 4'b0000, 2'd2, 0);
        step(0, 0, 4'b0000, 4'b0000, 2'd2, 0);
        // reset mid-BUSY, then search restarts at 3
        step(0, 1, 4'b1000, 4'b1000, 2'd3, 1);
        step(1, 1, 4'b1000, 4'b0000, 2'd0, 0);
        step(0, 1, 4'b1001, 4'b1000, 2'd3, 1);
        step(0, 1, 4'b0001, 4'b0000, 2'd3, 0);
        step(0, 1, 4'b0001, 4'b0001, 2'd0, 1);
        // long hold without timeout
        step(0, 1, 4'b0101, 4'b0001, 2'd0, 1);
        step(0, 1, 4'b0100, 4'b0000, 2'd0, 0);
        for (int i = 0; i < 50; i++) begin
            step(0, 1, 4'b0101, 4'b0100, 2'd2, 1);
        end
        step(0, 1, 4'b0001, 4'b0000, 2'd2, 0);
        step(0, 1, 4'b0001, 4'b0001, 2'd0, 1);
        step(0, 1, 4'b0000, 4'b0000, 2'd0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clock);
            waited++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
